// File: rtl/serial_bit_tx.sv
// serial_bit_tx
//   Parallel-in, serial-out bit-stream transmitter. A word presented on `data`
//   is captured when `start` is seen high on a rising `cp` edge in IDLE, then
//   shifted out MSB first on `d`. Each bit is held for BIT_CYCLES clock periods.
//   `dn` is the complement of `d`. A one-cycle `done` pulse follows each frame.
//   The outputs `d`, `busy` and `done` come straight from flops. `dn` is the
//   inverse of the `d` flop.
//
//   Optional feature macro: SER_TX_REPEAT_EN
//     When defined, `start` high in the final cycle of the last bit reloads the
//     shift register from `data`. The next frame then follows with no gap, and
//     no `done` pulse is produced between the two frames.
//     When undefined, every frame ends in the DONE state.
module serial_bit_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             cp,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             d,
    output logic             dn,
    output logic             busy,
    output logic             done
);

    // Counter widths: clog2 of the counted range, never narrower than 1 bit.
    localparam int BIT_W = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_ZERO = CYC_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   shift_s;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_s;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic [CYC_W-1:0]   cyc_cnt_s;

    logic               d_r;
    logic               d_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;

    logic               cyc_last_s;
    logic               bit_last_s;
    logic               reload_s;

    // Terminal-count decodes for the per-bit and per-frame counters.
    always_comb begin
        cyc_last_s = (cyc_cnt_r == CYC_LAST);
        bit_last_s = (bit_cnt_r == BIT_LAST);
    end

    // Back-to-back reload request: present only when the repeat feature is built in.
    always_comb begin
`ifdef SER_TX_REPEAT_EN
        reload_s = start;
`else
        reload_s = 1'b0;
`endif
    end

    // State and datapath registers. An asynchronous clear aborts any frame in progress.
    always_ff @(posedge cp or negedge clr_n) begin
        if (!clr_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= BIT_ZERO;
            cyc_cnt_r <= CYC_ZERO;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            cyc_cnt_r <= cyc_cnt_s;
        end
    end

    // Next-state and datapath update: capture, per-bit hold count, shift, frame end.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        cyc_cnt_s = cyc_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_SHIFT;
                    shift_s   = data;
                    bit_cnt_s = BIT_ZERO;
                    cyc_cnt_s = CYC_ZERO;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cyc_last_s) begin
                    cyc_cnt_s = CYC_ZERO;
                    if (bit_last_s) begin
                        bit_cnt_s = BIT_ZERO;
                        if (reload_s) begin
                            // Reload in place: the next frame's MSB follows with no gap.
                            state_s = ST_SHIFT;
                            shift_s = data;
                        end else begin
                            state_s = ST_DONE;
                            shift_s = shift_r << 1;
                        end
                    end else begin
                        state_s   = ST_SHIFT;
                        shift_s   = shift_r << 1;
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    state_s   = ST_SHIFT;
                    cyc_cnt_s = cyc_cnt_r + CYC_ONE;
                end
            end
            ST_DONE: begin
                // `start` is deliberately not looked at here.
                state_s   = ST_IDLE;
                bit_cnt_s = BIT_ZERO;
                cyc_cnt_s = CYC_ZERO;
            end
            default: begin
                state_s   = ST_IDLE;
                shift_s   = {WIDTH{1'b0}};
                bit_cnt_s = BIT_ZERO;
                cyc_cnt_s = CYC_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state, so the output flops change on the same edge as the state.
    always_comb begin
        d_s    = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                d_s    = 1'b0;
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_SHIFT: begin
                d_s    = shift_s[WIDTH-1];
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                d_s    = 1'b0;
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                d_s    = 1'b0;
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Output flops. The clear takes effect immediately, without waiting for a clock edge.
    always_ff @(posedge cp or negedge clr_n) begin
        if (!clr_n) begin
            d_r    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            d_r    <= d_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign d    = d_r;
    assign dn   = ~d_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx. Two instances share the clock, the clear and the
// stimulus: one with BIT_CYCLES=1 and one with BIT_CYCLES=2. A frame-level
// scoreboard queues the expected samples whenever a frame is accepted.
module tb_serial_bit_tx;

    localparam int W = 8;

    logic         cp    = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data  = 8'h00;

    logic d0, dn0, busy0, done0;
    logic d1, dn1, busy1, done1;

    serial_bit_tx #(.WIDTH(W), .BIT_CYCLES(1)) u_dut_bc1 (
        .cp(cp), .clr_n(clr_n), .start(start), .data(data),
        .d(d0), .dn(dn0), .busy(busy0), .done(done0)
    );

    serial_bit_tx #(.WIDTH(W), .BIT_CYCLES(2)) u_dut_bc2 (
        .cp(cp), .clr_n(clr_n), .start(start), .data(data),
        .d(d1), .dn(dn1), .busy(busy1), .done(done1)
    );

    always #5 cp = ~cp;

    typedef struct packed {
        logic d;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic         st;
        logic [W-1:0] dat;
        logic         ed;
        logic         eb;
        logic         eo;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   blocked0 = 0;
    int   blocked1 = 0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(input logic dd, input logic bb, input logic oo);
        exp_t e;
        e.d = dd; e.busy = bb; e.done = oo;
        return e;
    endfunction

    task automatic qpush(input int u, input exp_t e);
        if (u == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int u);
        if (u == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qdrop_back(input int u);
        exp_t e;
        if (u == 0) e = q0.pop_back(); else e = q1.pop_back();
    endtask

    task automatic check(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Queue the samples of one frame: the bits MSB first, each held bc cycles, then the done cycle.
    task automatic push_frame(input int u, input int bc, input logic [W-1:0] dat);
        for (int i = W - 1; i >= 0; i--) begin
            for (int c = 0; c < bc; c++) qpush(u, mk(dat[i], 1'b1, 1'b0));
        end
        qpush(u, mk(1'b0, 1'b0, 1'b1));
    endtask

    // Called before each edge: decide what this edge does for unit u.
    task automatic model_edge(input int u, input int bc, input logic st, input logic [W-1:0] dat);
        int blk;
        blk = (u == 0) ? blocked0 : blocked1;
        if (blk == 0 && st) begin
            push_frame(u, bc, dat);
            blk = W * bc + 1;
        end
`ifdef SER_TX_REPEAT_EN
        else if (blk == 2 && st) begin
            qdrop_back(u);
            push_frame(u, bc, dat);
            blk = W * bc + 1;
        end
`endif
        else begin
            if (blk > 0) blk--;
            if (qsize(u) == 0) qpush(u, mk(1'b0, 1'b0, 1'b0));
        end
        if (u == 0) blocked0 = blk; else blocked1 = blk;
    endtask

    task automatic compare_unit(input int u);
        exp_t  e;
        logic  ad, adn, ab, ao;
        string tag;
        tag = (u == 0) ? "bc1" : "bc2";
        if (u == 0) begin ad = d0; adn = dn0; ab = busy0; ao = done0; end
        else        begin ad = d1; adn = dn1; ab = busy1; ao = done1; end
        if (qsize(u) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.scoreboard: got empty queue expected an entry at %0t", tag, $time);
        end else begin
            e = qpop(u);
            check({tag, ".d"},    ad,  e.d);
            check({tag, ".dn"},   adn, ~e.d);
            check({tag, ".busy"}, ab,  e.busy);
            check({tag, ".done"}, ao,  e.done);
        end
    endtask

    // One clock: drive the inputs, update the model, then sample 1 ns after the edge.
    task automatic step(input logic st, input logic [W-1:0] dat);
        start = st;
        data  = dat;
        model_edge(0, 1, st, dat);
        model_edge(1, 2, st, dat);
        @(posedge cp);
        #1;
        compare_unit(0);
        compare_unit(1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, data);
    endtask

    task automatic check_cleared(input string name);
        check({name, ".bc1.d"},    d0,    1'b0);
        check({name, ".bc1.dn"},   dn0,   1'b1);
        check({name, ".bc1.busy"}, busy0, 1'b0);
        check({name, ".bc1.done"}, done0, 1'b0);
        check({name, ".bc2.d"},    d1,    1'b0);
        check({name, ".bc2.busy"}, busy1, 1'b0);
    endtask

    vec_t tbl[11];
    int   cnt;

    initial begin
        // A5 frame on the BIT_CYCLES=1 unit, with the samples worked out by hand.
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge cp);
            #1;
            check_cleared("reset");
        end
        start = 1'b0;
        clr_n = 1'b1;
        drain(3);

        // Table-driven A5 frame.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].st, tbl[i].dat);
            check("tbl.d",    d0,    tbl[i].ed);
            check("tbl.dn",   dn0,   ~tbl[i].ed);
            check("tbl.busy", busy0, tbl[i].eb);
            check("tbl.done", done0, tbl[i].eo);
        end
        drain(20);

        // 3C on the BIT_CYCLES=2 unit: busy must be high for exactly 16 cycles.
        cnt = 0;
        step(1'b1, 8'h3C);
        if (busy1) cnt++;
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 8'h3C);
            if (busy1) cnt++;
        end
        check_int("bc2.busy_len", cnt, 16);
        drain(4);

        // Change data and pulse start mid-frame: the frame is unaffected and no restart occurs.
        step(1'b1, 8'hA5);
        step(1'b0, 8'hFF);
        step(1'b0, 8'hFF);
        step(1'b1, 8'hFF);
        drain(22);

        // Hold start high with new data once the frame is running.
        cnt = 0;
        step(1'b1, 8'hA5);
        if (done0) cnt++;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'hFF);
            if (done0) cnt++;
        end
`ifdef SER_TX_REPEAT_EN
        check_int("repeat.done_count", cnt, 0);
`else
        check_int("repeat.done_count", cnt, 1);
`endif
        drain(25);

        // Start held high for 40 cycles.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'hC3);
            if (done0) cnt++;
        end
`ifdef SER_TX_REPEAT_EN
        check_int("hold40.done_count", cnt, 0);
`else
        check_int("hold40.done_count", cnt, 4);
`endif
        drain(25);

        // Asynchronous clear at bit 4 of an A5 frame.
        step(1'b1, 8'hA5);
        for (int i = 0; i < 4; i++) step(1'b0, 8'hA5);
        #2;
        clr_n = 1'b0;
        #1;
        check_cleared("async_clr");
        q0.delete();
        q1.delete();
        blocked0 = 0;
        blocked1 = 0;
        @(posedge cp);
        #1;
        check_cleared("clr_held");
        clr_n = 1'b1;
        drain(12);
        step(1'b1, 8'h5A);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
